// File: rtl/csplit_pkg.sv
// Shared types and helpers for the 4-way split/copy sequencing controller.
package csplit_pkg;

  localparam int unsigned N_BRANCH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // Timeout counter width; at least one bit so a disabled timeout still elaborates.
  function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
    int unsigned w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/csplit_ack_tracker.sv
// Per-token branch mask and acknowledge bookkeeping for the split controller.
module csplit_ack_tracker
  import csplit_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                accept,
  input  logic                capture,
  input  logic [N_BRANCH-1:0] mask_in,
  input  logic [N_BRANCH-1:0] ack_in,
  output logic                all_acked_c,
  output logic                spurious_c
);

  logic [N_BRANCH-1:0] mask_r;
  logic [N_BRANCH-1:0] ack_r;
  logic [N_BRANCH-1:0] bad_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mask_r <= '0;
      ack_r  <= '0;
    end else if (accept) begin
      mask_r <= mask_in;
      ack_r  <= '0;
    end else if (capture) begin
      ack_r <= ack_r | (ack_in & mask_r);
    end
  end

  // Includes acks arriving this cycle so completion is seen without an extra cycle.
  assign all_acked_c = ((ack_r | ack_in) & mask_r) == mask_r;

  // Outside the ISSUE/WAIT window every ack is unexpected.
  assign bad_c      = capture ? (ack_in & (~mask_r | ack_r)) : ack_in;
  assign spurious_c = |bad_c;

endmodule

// File: rtl/csplit4_seq_ctrl.sv
// Sequencing controller: accepts a token, drives enabled branches, collects acks, frees upstream.
module csplit4_seq_ctrl
  import csplit_pkg::*;
#(
  parameter int unsigned DATA_WIDTHI    = 32,
  parameter int unsigned COPY           = 0,
  parameter int unsigned SPLITTER       = 1,
  parameter int unsigned DATA_WIDTHOUT0 = 5,
  parameter int unsigned DATA_WIDTHOUT1 = 10,
  parameter int unsigned DATA_WIDTHOUT2 = 3,
  parameter int unsigned DATA_WIDTHOUT3 = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                                  clk,
  input  logic                                                  rstn,
  input  logic                                                  i_drive,
  input  logic [DATA_WIDTHI-1:0]                                i_data,
  input  logic [N_BRANCH-1:0]                                   i_mask_4,
  input  logic [N_BRANCH-1:0]                                   i_freeNext_4,
  input  logic                                                  i_clr,
  output logic                                                  o_free,
  output logic [N_BRANCH-1:0]                                   o_driveNext_4,
  output logic [COPY*DATA_WIDTHI+SPLITTER*DATA_WIDTHOUT0-1:0]   o_data0,
  output logic [COPY*DATA_WIDTHI+SPLITTER*DATA_WIDTHOUT1-1:0]   o_data1,
  output logic [COPY*DATA_WIDTHI+SPLITTER*DATA_WIDTHOUT2-1:0]   o_data2,
  output logic [COPY*DATA_WIDTHI+SPLITTER*DATA_WIDTHOUT3-1:0]   o_data3,
  output logic                                                  o_busy,
  output logic                                                  o_timeout,
  output logic                                                  o_overrun,
  output logic                                                  o_spurious
);

  localparam int unsigned W0    = COPY*DATA_WIDTHI + SPLITTER*DATA_WIDTHOUT0;
  localparam int unsigned W1    = COPY*DATA_WIDTHI + SPLITTER*DATA_WIDTHOUT1;
  localparam int unsigned W2    = COPY*DATA_WIDTHI + SPLITTER*DATA_WIDTHOUT2;
  localparam int unsigned W3    = COPY*DATA_WIDTHI + SPLITTER*DATA_WIDTHOUT3;
  localparam int unsigned OFF1  = DATA_WIDTHI - DATA_WIDTHOUT0;
  localparam int unsigned OFF2  = OFF1 - DATA_WIDTHOUT1;
  localparam int unsigned OFF3  = OFF2 - DATA_WIDTHOUT2;
  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 accept_c;
  logic                 capture_c;
  logic                 free_d;
  logic [N_BRANCH-1:0]  drive_d;
  logic                 timeout_set_c;
  logic                 overrun_set_c;
  logic                 all_acked_c;
  logic                 spurious_c;
  logic [W0-1:0]        slice0_c;
  logic [W1-1:0]        slice1_c;
  logic [W2-1:0]        slice2_c;
  logic [W3-1:0]        slice3_c;
  logic                 unused_data_c;

  // Branch payloads: full copy, or MSB-first consecutive slices.
  if (COPY != 0) begin : g_copy
    assign slice0_c = i_data;
    assign slice1_c = i_data;
    assign slice2_c = i_data;
    assign slice3_c = i_data;
  end else begin : g_split
    assign slice0_c = i_data[DATA_WIDTHI-1 -: W0];
    assign slice1_c = i_data[OFF1-1 -: W1];
    assign slice2_c = i_data[OFF2-1 -: W2];
    assign slice3_c = i_data[OFF3-1 -: W3];
  end

  // Low bits below the last slice are intentionally dropped.
  assign unused_data_c = ^i_data;

  assign capture_c     = (state_q == ISSUE) || (state_q == WAIT);
  assign overrun_set_c = i_drive && (state_q != IDLE);

  csplit_ack_tracker u_ack_tracker (
    .clk         (clk),
    .rstn        (rstn),
    .accept      (accept_c),
    .capture     (capture_c),
    .mask_in     (i_mask_4),
    .ack_in      (i_freeNext_4),
    .all_acked_c (all_acked_c),
    .spurious_c  (spurious_c)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    accept_c      = 1'b0;
    free_d        = 1'b0;
    drive_d       = '0;
    timeout_set_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_drive) begin
          accept_c = 1'b1;
          drive_d  = i_mask_4;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (all_acked_c) begin
          free_d  = 1'b1;
          state_d = RELEASE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          free_d        = 1'b1;
          timeout_set_c = 1'b1;
          state_d       = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      o_free        <= 1'b0;
      o_driveNext_4 <= '0;
      o_busy        <= 1'b0;
      o_timeout     <= 1'b0;
      o_overrun     <= 1'b0;
      o_spurious    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      o_free        <= free_d;
      o_driveNext_4 <= drive_d;
      o_busy        <= (state_d != IDLE);
      // Sticky flags: a set in the same cycle as i_clr wins.
      o_timeout     <= timeout_set_c | (o_timeout  & ~i_clr);
      o_overrun     <= overrun_set_c | (o_overrun  & ~i_clr);
      o_spurious    <= spurious_c    | (o_spurious & ~i_clr);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_data0 <= '0;
      o_data1 <= '0;
      o_data2 <= '0;
      o_data3 <= '0;
    end else if (accept_c) begin
      o_data0 <= slice0_c;
      o_data1 <= slice1_c;
      o_data2 <= slice2_c;
      o_data3 <= slice3_c;
    end
  end

endmodule

// File: tb/tb_csplit4_seq_ctrl.sv
// Directed vector bench for csplit4_seq_ctrl (splitter mode 5/10/3/2, timeout 8).
module tb_csplit4_seq_ctrl;

  typedef struct packed {
    logic        drive;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [3:0]  ack;
    logic        clr;
    logic        e_free;
    logic [3:0]  e_drv;
    logic        e_busy;
    logic        e_to;
    logic        e_ov;
    logic        e_sp;
    logic [19:0] e_dat;
  } vec_t;

  localparam logic [19:0] S_A5 = {5'h14, 10'h2D2, 3'h7, 2'h3};
  localparam logic [19:0] S_FF = {5'h1F, 10'h3FF, 3'h7, 2'h3};
  localparam logic [19:0] S_12 = {5'h02, 10'h11A, 3'h1, 2'h1};
  localparam logic [19:0] S_DE = {5'h1B, 10'h356, 3'h6, 2'h3};
  localparam logic [19:0] S_00 = 20'h0;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        i_drive = 1'b0;
  logic [31:0] i_data = '0;
  logic [3:0]  i_mask_4 = '0;
  logic [3:0]  i_freeNext_4 = '0;
  logic        i_clr = 1'b0;
  logic        o_free;
  logic [3:0]  o_driveNext_4;
  logic [4:0]  o_data0;
  logic [9:0]  o_data1;
  logic [2:0]  o_data2;
  logic [1:0]  o_data3;
  logic        o_busy;
  logic        o_timeout;
  logic        o_overrun;
  logic        o_spurious;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[$];
  string names[$];

  always #5 clk = ~clk;

  csplit4_seq_ctrl #(
    .DATA_WIDTHI    (32),
    .COPY           (0),
    .SPLITTER       (1),
    .DATA_WIDTHOUT0 (5),
    .DATA_WIDTHOUT1 (10),
    .DATA_WIDTHOUT2 (3),
    .DATA_WIDTHOUT3 (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_drive       (i_drive),
    .i_data        (i_data),
    .i_mask_4      (i_mask_4),
    .i_freeNext_4  (i_freeNext_4),
    .i_clr         (i_clr),
    .o_free        (o_free),
    .o_driveNext_4 (o_driveNext_4),
    .o_data0       (o_data0),
    .o_data1       (o_data1),
    .o_data2       (o_data2),
    .o_data3       (o_data3),
    .o_busy        (o_busy),
    .o_timeout     (o_timeout),
    .o_overrun     (o_overrun),
    .o_spurious    (o_spurious)
  );

  task automatic add(input string nm, input logic dr, input logic [31:0] d,
                     input logic [3:0] m, input logic [3:0] a, input logic c,
                     input logic ef, input logic [3:0] ed, input logic eb,
                     input logic eto, input logic eov, input logic esp,
                     input logic [19:0] edat);
    vec_t v;
    v.drive = dr; v.data = d; v.mask = m; v.ack = a; v.clr = c;
    v.e_free = ef; v.e_drv = ed; v.e_busy = eb;
    v.e_to = eto; v.e_ov = eov; v.e_sp = esp; v.e_dat = edat;
    vecs.push_back(v);
    names.push_back(nm);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [28:0] snap();
    return {o_free, o_driveNext_4, o_busy, o_timeout, o_overrun, o_spurious,
            o_data0, o_data1, o_data2, o_data3};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [28:0] act;
    logic [28:0] expv;

    // name, drive, data, mask, ack, clr | free, drv, busy, to, ov, sp, data
    add("t1_acc",   1, 32'hA5A5_F00D, 4'hF, 4'h0, 0,  0, 4'hF, 1, 0, 0, 0, S_A5);
    add("t1_iss",   0, 32'h0,         4'h0, 4'h0, 0,  0, 4'h0, 1, 0, 0, 0, S_A5);
    add("t1_wait",  0, 32'h0,         4'h0, 4'h0, 0,  0, 4'h0, 1, 0, 0, 0, S_A5);
    add("t1_ack",   0, 32'h0,         4'h0, 4'hF, 0,  1, 4'h0, 1, 0, 0, 0, S_A5);
    add("t1_rel",   0, 32'h0,         4'h0, 4'h0, 0,  0, 4'h0, 0, 0, 0, 0, S_A5);
    add("t3_acc",   1, 32'hFFFF_FFFF, 4'h0, 4'h0, 0,  0, 4'h0, 1, 0, 0, 0, S_FF);
    add("t3_iss",   0, 32'h0,         4'h0, 4'h0, 0,  0, 4'h0, 1, 0, 0, 0, S_FF);
    add("t3_wait",  0, 32'h0,         4'h0, 4'h0, 0,  1, 4'h0, 1, 0, 0, 0, S_FF);
    add("t3_rel",   0, 32'h0,         4'h0, 4'h0, 0,  0, 4'h0, 0, 0, 0, 0, S_FF);
    add("t2_acc",   1, 32'h1234_5678, 4'h5, 4'h0, 0,  0, 4'h5, 1, 0, 0, 0, S_12);
    add("t2_iss",   0, 32'h0,         4'h0, 4'h0, 0,  0, 4'h0, 1, 0, 0, 0, S_12);
    add("t2_ack0",  0, 32'h0,         4'h0, 4'h1, 0,  0, 4'h0, 1, 0, 0, 0, S_12);
    add("t2_w1",    0, 32'h0,         4'h0, 4'h0, 0,  0, 4'h0, 1, 0, 0, 0, S_12);
    add("t2_w2",    0, 32'h0,         4'h0, 4'h0, 0,  0, 4'h0, 1, 0, 0, 0, S_12);
    add("t2_ack2",  0, 32'h0,         4'h0, 4'h4, 0,  1, 4'h0, 1, 0, 0, 0, S_12);
    add("t2_reldrv",1, 32'hFFFF_FFFF, 4'hF, 4'h0, 0,  0, 4'h0, 0, 0, 1, 0, S_12);
    add("t2_clr",   0, 32'h0,         4'h0, 4'h0, 1,  0, 4'h0, 0, 0, 0, 0, S_12);
    add("z_acc",    1, 32'hDEAD_BEEF, 4'h3, 4'h0, 0,  0, 4'h3, 1, 0, 0, 0, S_DE);
    add("z_issack", 0, 32'h0,         4'h0, 4'h3, 0,  0, 4'h0, 1, 0, 0, 0, S_DE);
    add("z_wait",   0, 32'h0,         4'h0, 4'h0, 0,  1, 4'h0, 1, 0, 0, 0, S_DE);
    add("z_rel",    0, 32'h0,         4'h0, 4'h0, 0,  0, 4'h0, 0, 0, 0, 0, S_DE);
    add("t5_acc",   1, 32'h1234_5678, 4'hD, 4'h0, 0,  0, 4'hD, 1, 0, 0, 0, S_12);
    add("t5_iss",   0, 32'h0,         4'h0, 4'h0, 0,  0, 4'h0, 1, 0, 0, 0, S_12);
    add("t5_ovsp",  1, 32'hFFFF_FFFF, 4'hF, 4'h2, 0,  0, 4'h0, 1, 0, 1, 1, S_12);
    add("t5_ack",   0, 32'h0,         4'h0, 4'hD, 0,  1, 4'h0, 1, 0, 1, 1, S_12);
    add("t5_rel",   0, 32'h0,         4'h0, 4'h0, 0,  0, 4'h0, 0, 0, 1, 1, S_12);
    add("t5_clr",   0, 32'h0,         4'h0, 4'h0, 1,  0, 4'h0, 0, 0, 0, 0, S_12);
    add("idle_ack", 0, 32'h0,         4'h0, 4'h8, 0,  0, 4'h0, 0, 0, 0, 1, S_12);
    add("clr_set",  0, 32'h0,         4'h0, 4'h1, 1,  0, 4'h0, 0, 0, 0, 1, S_12);
    add("idle_clr", 0, 32'h0,         4'h0, 4'h0, 1,  0, 4'h0, 0, 0, 0, 0, S_12);
    add("t4_acc",   1, 32'h0000_0000, 4'hF, 4'h0, 0,  0, 4'hF, 1, 0, 0, 0, S_00);
    add("t4_iss",   0, 32'h0,         4'h0, 4'h0, 0,  0, 4'h0, 1, 0, 0, 0, S_00);
    add("t4_ack3",  0, 32'h0,         4'h0, 4'h7, 0,  0, 4'h0, 1, 0, 0, 0, S_00);
    for (int k = 0; k < 6; k++)
      add($sformatf("t4_w%0d", k), 0, 32'h0, 4'h0, 4'h0, 0, 0, 4'h0, 1, 0, 0, 0, S_00);
    add("t4_to",    0, 32'h0,         4'h0, 4'h0, 0,  1, 4'h0, 1, 1, 0, 0, S_00);
    add("t4_rel",   0, 32'h0,         4'h0, 4'h0, 0,  0, 4'h0, 0, 1, 0, 0, S_00);
    add("t4_clr",   0, 32'h0,         4'h0, 4'h0, 1,  0, 4'h0, 0, 0, 0, 0, S_00);

    #1 rstn = 1'b0;
    #2;
    chk("reset_state", 32'(snap()), 32'h0);
    @(posedge clk);
    #1 rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      i_drive      = vecs[i].drive;
      i_data       = vecs[i].data;
      i_mask_4     = vecs[i].mask;
      i_freeNext_4 = vecs[i].ack;
      i_clr        = vecs[i].clr;
      @(posedge clk);
      #1;
      act  = snap();
      expv = {vecs[i].e_free, vecs[i].e_drv, vecs[i].e_busy, vecs[i].e_to,
              vecs[i].e_ov, vecs[i].e_sp, vecs[i].e_dat};
      n_vec++;
      if (act !== expv) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", names[i], act, expv);
      end
    end
    i_drive = 0; i_data = '0; i_mask_4 = '0; i_freeNext_4 = '0; i_clr = 0;

    // Asynchronous reset in the middle of a token, then a fresh token.
    i_drive = 1; i_data = 32'hA5A5_F00D; i_mask_4 = 4'hF;
    @(posedge clk); #1;
    i_drive = 0; i_data = '0; i_mask_4 = '0;
    chk("rst_pre_drv", 32'(o_driveNext_4), 32'hF);
    @(posedge clk); #1;
    chk("rst_pre_busy", 32'(o_busy), 32'h1);
    #1 rstn = 1'b0;
    #1;
    chk("rst_async", 32'(snap()), 32'h0);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_no_free", 32'({o_free, o_busy}), 32'h0);
    i_drive = 1; i_data = 32'h1234_5678; i_mask_4 = 4'h6;
    @(posedge clk); #1;
    i_drive = 0; i_data = '0; i_mask_4 = '0;
    chk("rst_new_drv", 32'(o_driveNext_4), 32'h6);
    chk("rst_new_dat", 32'({o_data0, o_data1, o_data2, o_data3}), 32'(S_12));
    i_freeNext_4 = 4'h6;
    @(posedge clk); #1;
    i_freeNext_4 = '0;
    chk("rst_new_wait", 32'({o_free, o_busy}), 32'h1);
    @(posedge clk); #1;
    chk("rst_new_free", 32'({o_free, o_busy, o_spurious}), 32'h6);
    @(posedge clk); #1;
    chk("rst_new_idle", 32'({o_free, o_busy}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csplit4_seq_ctrl.md
# csplit4_seq_ctrl

Clocked sequencing controller for a 4-way split/copy stage. It accepts one input token per drive/free handshake and registers the data slices for four downstream branches. It pulses drive only to the branches enabled by a per-token mask, collects their free acknowledgements, and returns free upstream once every enabled branch has acknowledged or a timeout expires. It bridges the clocked domain to four split consumers.

## Interface
- DATA_WIDTHI, 32, input data width
- COPY, 0, 1 = every branch receives the full i_data; mutually exclusive with SPLITTER
- SPLITTER, 1, 1 = branches receive consecutive MSB-first slices of i_data
- DATA_WIDTHOUT0..3, 5/10/3/2, slice widths for branches 0..3; sum ≤ DATA_WIDTHI
- TIMEOUT_CYCLES, 255, maximum wait for acknowledgements; 0 disables the timeout
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- i_drive  in  1  one-cycle token-request pulse
- i_data  in  DATA_WIDTHI  token data, valid in the i_drive cycle
- i_mask_4  in  4  branch enables, sampled with i_drive
- i_freeNext_4  in  4  per-branch one-cycle acknowledge pulses
- i_clr  in  1  clears sticky flags
- o_free  out  1  one-cycle upstream acknowledge
- o_driveNext_4  out  4  per-branch one-cycle drive pulses
- o_data0..o_data3  out  COPY*DATA_WIDTHI+SPLITTER*DATA_WIDTHOUTn  registered branch data
- o_busy  out  1  high in every state except IDLE
- o_timeout  out  1  sticky; set when a token is aborted by timeout
- o_overrun  out  1  sticky; set when i_drive arrives outside IDLE
- o_spurious  out  1  sticky; set by an ack on a disabled or already-acked branch

## Operation
- FSM states: IDLE, ISSUE, WAIT, RELEASE.
- IDLE: on i_drive:
  - register i_data slices into o_data0..3;
  - latch i_mask_4 into mask_r;
  - clear ack_r;
  - go to ISSUE.
- ISSUE: o_driveNext_4 = mask_r for exactly one cycle; go to WAIT.
- WAIT:
  - ack_r |= i_freeNext_4 & mask_r on every cycle;
  - when (ack_r | new acks) covers mask_r, go to RELEASE;
  - the timeout counter increments each WAIT cycle; when count == TIMEOUT_CYCLES-1 with acks incomplete, set o_timeout and go to RELEASE.
- RELEASE: o_free = 1 for one cycle; go to IDLE.
- Slicing (SPLITTER=1): o_data0 = i_data[MSB -: W0], o_data1 = the next W1 bits below it, and so on; bits below the W3 slice are unused.
- Slicing (COPY=1): all four outputs equal i_data.
- o_data* hold their value from acceptance until the next accept.
- Acks are also captured during the ISSUE cycle, so a zero-latency consumer is supported.
- Mask 0000: ISSUE drives nothing, WAIT completes immediately, o_free follows.
- i_drive in ISSUE, WAIT or RELEASE: dropped and o_overrun set. It is never queued.
- Ack on a branch outside mask_r, or a repeat ack: ignored, o_spurious set.
- Acks in IDLE: ignored, o_spurious set.
- i_clr clears all sticky flags. If i_clr and a new set event occur in the same cycle, set wins.

## Timing
- Reset state: IDLE. All outputs are 0: o_free, o_driveNext_4, o_data0..3, o_busy, all sticky flags, mask_r, ack_r and the timeout counter.
- i_drive sampled at edge of cycle T:
  - T+1: o_driveNext_4 pulse, o_data valid;
  - T+2: first WAIT cycle;
  - o_free asserts in the cycle after the completing ack is sampled.
- Minimum token period: 4 cycles (T accept, ISSUE, WAIT, RELEASE). The next i_drive is accepted in the cycle after o_free.
- Timeout abort: o_free at T+2+TIMEOUT_CYCLES.
- Reset mid-operation: asynchronous return to IDLE with all outputs cleared. The in-flight token is lost; no o_free is issued.

## Structure
- Package csplit_pkg:
  - state enum {IDLE, ISSUE, WAIT, RELEASE};
  - constant N_BRANCH = 4;
  - counter width function clog2(TIMEOUT_CYCLES+1).
- Sub-module csplit_ack_tracker: holds mask_r/ack_r, produces the all_acked and spurious signals, with synchronous clear on accept. It is instantiated once.
- Slice arithmetic and the FSM stay in the top module.

## Test plan
- Mask 1111, data 0xA5A5_F00D, acks on all branches in T+3 → o_driveNext_4=1111 at T+1, slices 0x14/0x2D2/0x7/0x3, o_free at T+4.
- Mask 0101, acks for branch 0 at T+2 and branch 2 at T+5 → o_driveNext_4=0101, o_free at T+6, no flags.
- Mask 0000 → no drive pulses, o_free at T+3.
- TIMEOUT_CYCLES=8, mask 1111, branch 3 never acks → o_free at T+10, o_timeout=1; i_clr clears it.
- i_drive at T+2 while in WAIT, plus an ack on disabled branch 1 (mask 1101) → o_overrun=1, o_spurious=1, token completes normally.
- rstn low at T+2 → all outputs 0 immediately; after release a new i_drive is accepted normally.
